// File: rtl/exc_pkg.sv
// Shared types and constants for the exception responder and its CP0 register set.
package exc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StVector,
        StHandler,
        StReturn
    } state_e;

    localparam logic [4:0] EXC_RI = 5'd10;
    localparam logic [4:0] EXC_OV = 5'd12;

    localparam logic [4:0] STATUS = 5'd12;
    localparam logic [4:0] CAUSE  = 5'd13;
    localparam logic [4:0] EPC    = 5'd14;

endpackage

// File: rtl/cp0_regs.sv
// CP0 storage for EPC, cause code, sticky lost flag and EXL, with mtc0 gating and mfc0 read mux.
module cp0_regs
    import exc_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              capture,
    input  logic [ADDR_W-1:0] capture_pc,
    input  logic [4:0]        capture_code,
    input  logic              set_lost,
    input  logic              clr_exl,
    input  logic              in_handler,
    input  logic              we,
    input  logic [4:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] epc,
    output logic              exl
);

    logic [4:0] exccode;
    logic       lost;
    logic       wr_epc;
    logic       wr_status;

    assign wr_epc    = in_handler && we && (addr == EPC);
    assign wr_status = in_handler && we && (addr == STATUS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            epc     <= '0;
            exccode <= '0;
            lost    <= 1'b0;
            exl     <= 1'b0;
        end else begin
            if (capture) begin
                epc     <= capture_pc;
                exccode <= capture_code;
                exl     <= 1'b1;
            end else if (wr_epc) begin
                epc <= ADDR_W'(wdata);
            end
            if (clr_exl) begin
                exl <= 1'b0;
            end
            // A nested fault in the same cycle as a software clear keeps the flag set.
            if (set_lost) begin
                lost <= 1'b1;
            end else if (wr_status) begin
                lost <= wdata[4];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            STATUS:  rdata = {27'b0, lost, 2'b0, exl, 1'b0};
            CAUSE:   rdata = {25'b0, exccode, 2'b0};
            EPC:     rdata = 32'(epc);
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/exc_unit.sv
// Exception responder: captures faults, then sequences flush, vector, handler and return.
module exc_unit
    import exc_pkg::*;
#(
    parameter logic [31:0] VECTOR_ADDR = 32'h8000_0180,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              exception,
    input  logic              overflow,
    input  logic              eret,
    input  logic [ADDR_W-1:0] instr_pc,
    input  logic              cp0_we,
    input  logic [4:0]        cp0_addr,
    input  logic [31:0]       cp0_wdata,
    output logic [31:0]       cp0_rdata,
    output logic              flush,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              exl
);

    state_e            state;
    state_e            state_next;
    logic              capture;
    logic              set_lost;
    logic              clr_exl;
    logic [4:0]        code;
    logic [ADDR_W-1:0] epc;

    // eret outside the handler is illegal, so it shares the RI code with the decoder fault.
    assign code = (exception || eret) ? EXC_RI : EXC_OV;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        set_lost    = 1'b0;
        clr_exl     = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        unique case (state)
            StIdle: begin
                if (exception || overflow || eret) begin
                    capture    = 1'b1;
                    state_next = StFlush;
                end
            end
            StFlush: begin
                flush      = 1'b1;
                state_next = StVector;
            end
            StVector: begin
                redirect    = 1'b1;
                redirect_pc = ADDR_W'(VECTOR_ADDR);
                state_next  = StHandler;
            end
            StHandler: begin
                if (eret) begin
                    state_next = StReturn;
                end else if (exception || overflow) begin
                    set_lost = 1'b1;
                end
            end
            StReturn: begin
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = epc;
                clr_exl     = 1'b1;
                state_next  = StIdle;
            end
            default: state_next = StIdle;
        endcase
    end

    cp0_regs #(
        .ADDR_W(ADDR_W)
    ) u_cp0_regs (
        .clk          (clk),
        .reset_n      (reset_n),
        .capture      (capture),
        .capture_pc   (instr_pc),
        .capture_code (code),
        .set_lost     (set_lost),
        .clr_exl      (clr_exl),
        .in_handler   (state == StHandler),
        .we           (cp0_we),
        .addr         (cp0_addr),
        .wdata        (cp0_wdata),
        .rdata        (cp0_rdata),
        .epc          (epc),
        .exl          (exl)
    );

endmodule

// File: tb/tb_exc_unit.sv
// Scoreboard bench for exc_unit: expected flush/redirect events are queued by the stimulus
// and consumed by a monitor; CP0 reads are compared directly.
module tb_exc_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        exception = 1'b0;
    logic        overflow = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] instr_pc = '0;
    logic        cp0_we = 1'b0;
    logic [4:0]  cp0_addr = '0;
    logic [31:0] cp0_wdata = '0;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exl;

    typedef struct packed {
        logic        f;
        logic        r;
        logic [31:0] pc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    localparam logic [31:0] VEC = 32'h8000_0180;

    exc_unit #(
        .VECTOR_ADDR (VEC),
        .ADDR_W      (32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .exception   (exception),
        .overflow    (overflow),
        .eret        (eret),
        .instr_pc    (instr_pc),
        .cp0_we      (cp0_we),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .cp0_rdata   (cp0_rdata),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exl         (exl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
        cp0_addr = a;
        #1;
        chk(name, cp0_rdata, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        exception = 1'b0;
        overflow  = 1'b0;
        eret      = 1'b0;
        cp0_we    = 1'b0;
    endtask

    task automatic push_entry();
        exp_q.push_back('{f: 1'b1, r: 1'b0, pc: 32'h0});
        exp_q.push_back('{f: 1'b0, r: 1'b1, pc: VEC});
    endtask

    // Trigger in IDLE, then walk FLUSH and VECTOR into HANDLER.
    task automatic take(input logic ex, input logic ov, input logic er, input logic [31:0] pc);
        push_entry();
        exception = ex;
        overflow  = ov;
        eret      = er;
        instr_pc  = pc;
        cyc();
        clr();
        cyc();
        cyc();
    endtask

    task automatic do_eret(input logic [31:0] target);
        exp_q.push_back('{f: 1'b1, r: 1'b1, pc: target});
        eret = 1'b1;
        cyc();
        clr();
        cyc();
    endtask

    always @(negedge clk) begin
        if (reset_n && (flush || redirect)) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_event: got f=%0b r=%0b pc=0x%08h expected none",
                         flush, redirect, redirect_pc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("event", {30'b0, flush, redirect}, {30'b0, e.f, e.r});
                chk("event_pc", redirect_pc, e.pc);
            end
        end
    end

    initial begin
        #2;
        chk("reset_flush", {31'b0, flush}, 32'h0);
        chk("reset_redirect_pc", redirect_pc, 32'h0);
        rd(5'd12, 32'h0, "reset_status");
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        // Illegal instruction from IDLE
        take(1'b1, 1'b0, 1'b0, 32'h0040_0010);
        rd(5'd14, 32'h0040_0010, "ri_epc");
        rd(5'd13, 32'h0000_0028, "ri_cause");
        rd(5'd12, 32'h0000_0002, "ri_status");
        rd(5'd3, 32'h0, "unmapped_reg");
        chk("exl_handler", {31'b0, exl}, 32'h1);

        // Nested fault in HANDLER: sticky lost only, no events
        exception = 1'b1;
        instr_pc  = 32'h0040_0100;
        cyc();
        clr();
        rd(5'd14, 32'h0040_0010, "nested_epc");
        rd(5'd12, 32'h0000_0012, "nested_status");
        cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0;
        cyc();
        clr();
        rd(5'd12, 32'h0000_0002, "lost_cleared");

        // mtc0 EPC then eret
        cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0040_0014;
        cyc();
        clr();
        do_eret(32'h0040_0014);
        chk("exl_after_ret", {31'b0, exl}, 32'h0);
        rd(5'd12, 32'h0, "status_after_ret");

        // Overflow alone
        take(1'b0, 1'b1, 1'b0, 32'h0040_0030);
        rd(5'd13, 32'h0000_0030, "ov_cause");
        rd(5'd14, 32'h0040_0030, "ov_epc");
        // mtc0 EPC in the same cycle as eret
        cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0040_0044;
        do_eret(32'h0040_0044);

        // RI wins over Ov
        take(1'b1, 1'b1, 1'b0, 32'h0040_0050);
        rd(5'd13, 32'h0000_0028, "prio_cause");
        do_eret(32'h0040_0050);

        // mtc0 outside HANDLER is ignored
        cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
        cyc();
        clr();
        rd(5'd14, 32'h0040_0050, "idle_mtc0_ignored");

        // eret in IDLE is RI
        take(1'b0, 1'b0, 1'b1, 32'h0040_0020);
        rd(5'd14, 32'h0040_0020, "eret_idle_epc");
        rd(5'd13, 32'h0000_0028, "eret_idle_cause");
        do_eret(32'h0040_0020);

        // Reset in the middle of FLUSH
        exp_q.push_back('{f: 1'b1, r: 1'b0, pc: 32'h0});
        exception = 1'b1;
        instr_pc  = 32'h0040_0060;
        cyc();
        clr();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_flush", {31'b0, flush}, 32'h0);
        chk("rst_redirect", {31'b0, redirect}, 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_exl", {31'b0, exl}, 32'h0);
        rd(5'd14, 32'h0, "rst_epc");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd12, 32'h0, "rst_status");
        #1;
        reset_n = 1'b1;

        // Fresh exception after reset, with a trigger during FLUSH that must be ignored
        push_entry();
        exception = 1'b1;
        instr_pc  = 32'h0040_0070;
        cyc();
        clr();
        overflow = 1'b1;
        instr_pc = 32'h0000_0999;
        cyc();
        clr();
        cyc();
        rd(5'd14, 32'h0040_0070, "post_rst_epc");
        rd(5'd13, 32'h0000_0028, "post_rst_cause");
        rd(5'd12, 32'h0000_0002, "post_rst_status");
        do_eret(32'h0040_0070);
        cyc();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
